// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Main control FSM for a multicycle MIPS datapath. It sequences fetch, decode,
// execute, memory access and writeback over a shared ALU. It drives the ALU
// operation code, the operand selects and every datapath enable. A memory-ready
// handshake stalls the machine in the states that touch the unified memory.
//
// Ports
//   clk         in   system clock, rising-edge active
//   rst_n       in   asynchronous active-low reset (state -> FETCH)
//   Opcode[5:0] in   IR[31:26]
//   Funct[5:0]  in   IR[5:0]
//   Zero        in   ALU zero flag, used only in BRANCH
//   MemReady    in   memory access completes this cycle
//   IorD        out  memory address select (0 PC, 1 ALUOut)
//   MemWrite    out  memory write strobe
//   IRWrite     out  instruction register load
//   RegDst      out  register write address (0 rt, 1 rd)
//   MemtoReg    out  register write data (0 ALUOut, 1 Data)
//   RegWrite    out  register file write enable
//   ALUSrcA     out  ALU A operand (0 PC, 1 regA)
//   ALUSrcB[1:0]out  ALU B operand (00 regB, 01 4, 10 SignImm, 11 SignImm<<2)
//   ALUControl[2:0] out ALU operation (010 add, 110 sub, 000 and, 001 or, 111 slt)
//   PCSrc[1:0]  out  next-PC select (00 ALUResult, 01 ALUOut, 10 jump target)
//   PCEn        out  PC load enable = PCWrite | (Branch & Zero)
//   Illegal     out  one-cycle pulse in DECODE on unsupported opcode/funct
//   State[3:0]  out  current state, for debug
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Operand select codes
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  // True for the R-type function codes this controller can execute.
  function automatic logic funct_supported(input logic [5:0] fn);
    logic ok;
    case (fn)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
      default:                               ok = 1'b0;
    endcase
    return ok;
  endfunction

  // ALU operation for an R-type function code; add for anything unknown.
  function automatic logic [2:0] alu_for_funct(input logic [5:0] fn);
    logic [2:0] op;
    case (fn)
      FN_ADD:  op = ALU_ADD;
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  state_e state_q;
  state_e state_d;
  logic   pc_write_s;
  logic   branch_s;

  // State register, cleared asynchronously to the reset state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= state_e'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore/Mealy output decode.
  always_comb begin
    state_d    = S_FETCH;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ALUControl = ALU_ADD;
    PCSrc      = PCSRC_ALU;
    Illegal    = 1'b0;
    pc_write_s = 1'b0;
    branch_s   = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC+4 computed every cycle; IR and PC only commit when memory is ready.
        ALUSrcB    = SRCB_FOUR;
        IRWrite    = MemReady;
        pc_write_s = MemReady;
        if (MemReady) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        ALUSrcB = SRCB_IMM2;
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (funct_supported(Funct)) begin
              state_d = S_EXECUTE;
            end else begin
              state_d = S_FETCH;
              Illegal = 1'b1;
            end
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            Illegal = 1'b1;
          end
        endcase
      end

      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        // Only lw and sw reach this state, so anything not lw is a store.
        if (Opcode == OP_LW) begin
          state_d = S_MEMREAD;
        end else begin
          state_d = S_MEMWRITE;
        end
      end

      S_MEMREAD: begin
        IorD = 1'b1;
        if (MemReady) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMREAD;
        end
      end

      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_MEMWRITE: begin
        // Strobe is held for the whole access, not gated by MemReady.
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWRITE;
        end
      end

      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_REG;
        ALUControl = alu_for_funct(Funct);
        state_d    = S_ALUWB;
      end

      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_REG;
        ALUControl = ALU_SUB;
        PCSrc      = PCSRC_OUT;
        branch_s   = 1'b1;
        state_d    = S_FETCH;
      end

      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = S_ADDIWB;
      end

      S_ADDIWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_JUMP: begin
        PCSrc      = PCSRC_JUMP;
        pc_write_s = 1'b1;
        state_d    = S_FETCH;
      end

      default: begin
        // Unused encodings: all enables stay low, recover to FETCH.
        state_d = S_FETCH;
      end
    endcase

    // Zero only matters while branch_s is set, i.e. in BRANCH.
    PCEn = pc_write_s | (branch_s & Zero);
  end

  assign State = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for mips_multicycle_ctrl. Each instruction is
// walked from FETCH back to FETCH; per-state observations are collected and
// compared against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] PCSrc;
  logic       PCEn, Illegal;
  logic [3:0] State;

  mips_multicycle_ctrl #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .PCSrc(PCSrc), .PCEn(PCEn), .Illegal(Illegal), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observations collected by run_instr
  int         cyc, regw_cnt, memw_cnt, irw_cnt, pcen_cnt, ill_cnt;
  int         memw_bad, memread_bad, memwb_cnt, wr_viol;
  logic [3:0] ill_state;
  logic [2:0] exec_alu, br_alu;
  logic [1:0] exec_srcb, br_pcsrc, j_pcsrc;
  logic       aluwb_regdst, br_pcen, j_pcen, done;

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fstall, input int mstall);
    int         fs_cnt;
    int         ms_cnt;
    logic [3:0] st;
    fs_cnt = 0; ms_cnt = 0;
    cyc = 0; regw_cnt = 0; memw_cnt = 0; irw_cnt = 0; pcen_cnt = 0; ill_cnt = 0;
    memw_bad = 0; memread_bad = 0; memwb_cnt = 0; wr_viol = 0;
    ill_state = 4'hf; exec_alu = 3'b101; br_alu = 3'b101; exec_srcb = 2'b11;
    br_pcsrc = 2'b11; j_pcsrc = 2'b11; aluwb_regdst = 1'b0; br_pcen = 1'bx; j_pcen = 1'b0;
    done = 1'b0;
    Opcode = op; Funct = fn; Zero = z;
    for (int k = 0; k < 60; k++) begin
      st = State;
      if (st == 4'd0) begin
        MemReady = (fs_cnt < fstall) ? 1'b0 : 1'b1;
        fs_cnt = fs_cnt + 1;
      end else if (st == 4'd3 || st == 4'd5) begin
        MemReady = (ms_cnt < mstall) ? 1'b0 : 1'b1;
        ms_cnt = ms_cnt + 1;
      end else begin
        MemReady = 1'b1;
      end
      #1;
      if (RegWrite) regw_cnt = regw_cnt + 1;
      if (MemWrite) memw_cnt = memw_cnt + 1;
      if (MemWrite && !IorD) memw_bad = memw_bad + 1;
      if (IRWrite) irw_cnt = irw_cnt + 1;
      if (PCEn) pcen_cnt = pcen_cnt + 1;
      if (Illegal) begin
        ill_cnt = ill_cnt + 1;
        ill_state = State;
      end
      if (int'(RegWrite) + int'(MemWrite) + int'(IRWrite) > 1) wr_viol = wr_viol + 1;
      if (st == 4'd3 && !IorD) memread_bad = memread_bad + 1;
      if (st == 4'd4 && MemtoReg && RegWrite) memwb_cnt = memwb_cnt + 1;
      if (st == 4'd6) begin
        exec_alu = ALUControl;
        exec_srcb = ALUSrcB;
      end
      if (st == 4'd7) aluwb_regdst = RegDst;
      if (st == 4'd8) begin
        br_alu = ALUControl;
        br_pcsrc = PCSrc;
        br_pcen = PCEn;
      end
      if (st == 4'd11) begin
        j_pcsrc = PCSrc;
        j_pcen = PCEn;
      end
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if (State == 4'd0 && st != 4'd0) begin
        done = 1'b1;
        break;
      end
    end
    check_eq("completed", 32'(done), 32'd1);
  endtask

  logic [5:0] fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] alu_tab[5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; MemReady = 1'b0; Opcode = 6'd0; Funct = 6'b100000; Zero = 1'b0;
    #12;
    // Reset values
    check_eq("rst_state",   32'(State), 32'd0);
    check_eq("rst_regw",    32'(RegWrite), 32'd0);
    check_eq("rst_memw",    32'(MemWrite), 32'd0);
    check_eq("rst_irw",     32'(IRWrite), 32'd0);
    check_eq("rst_pcen",    32'(PCEn), 32'd0);
    check_eq("rst_srcb",    32'(ALUSrcB), 32'd1);
    check_eq("rst_aluctl",  32'(ALUControl), 32'd2);
    check_eq("rst_pcsrc",   32'(PCSrc), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("stall_fetch", 32'(State), 32'd0);

    // Async reset mid-EXECUTE
    MemReady = 1'b1; Opcode = 6'b000000; Funct = 6'b100000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("in_execute", 32'(State), 32'd6);
    #2;
    rst_n = 1'b0; MemReady = 1'b0;
    #1;
    check_eq("arst_state", 32'(State), 32'd0);
    check_eq("arst_regw",  32'(RegWrite), 32'd0);
    check_eq("arst_memw",  32'(MemWrite), 32'd0);
    check_eq("arst_irw",   32'(IRWrite), 32'd0);
    check_eq("arst_pcen",  32'(PCEn), 32'd0);
    MemReady = 1'b1;
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_decode", 32'(State), 32'd1);
    rst_n = 1'b0; MemReady = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("back_fetch", 32'(State), 32'd0);

    // R-type sweep; Zero held high to show it is ignored outside BRANCH
    for (int i = 0; i < 5; i++) begin
      run_instr(6'b000000, fn_tab[i], 1'b1, 0, 0);
      check_eq($sformatf("r%0d_cycles", i), 32'(cyc), 32'd4);
      check_eq($sformatf("r%0d_alu", i), 32'(exec_alu), 32'(alu_tab[i]));
      check_eq($sformatf("r%0d_srcb", i), 32'(exec_srcb), 32'd0);
      check_eq($sformatf("r%0d_regdst", i), 32'(aluwb_regdst), 32'd1);
      check_eq($sformatf("r%0d_regw", i), 32'(regw_cnt), 32'd1);
      check_eq($sformatf("r%0d_pcen", i), 32'(pcen_cnt), 32'd1);
    end

    // lw, no stalls
    run_instr(6'b100011, 6'd0, 1'b0, 0, 0);
    check_eq("lw_cycles", 32'(cyc), 32'd5);
    // lw with 2 fetch stalls and 3 read stalls
    run_instr(6'b100011, 6'd0, 1'b0, 2, 3);
    check_eq("lws_cycles",  32'(cyc), 32'd10);
    check_eq("lws_iord",    32'(memread_bad), 32'd0);
    check_eq("lws_memwb",   32'(memwb_cnt), 32'd1);
    check_eq("lws_regw",    32'(regw_cnt), 32'd1);
    check_eq("lws_irw",     32'(irw_cnt), 32'd1);
    check_eq("lws_memw",    32'(memw_cnt), 32'd0);

    // sw
    run_instr(6'b101011, 6'd0, 1'b0, 0, 0);
    check_eq("sw_cycles", 32'(cyc), 32'd4);
    check_eq("sw_memw",   32'(memw_cnt), 32'd1);
    check_eq("sw_iord",   32'(memw_bad), 32'd0);
    check_eq("sw_regw",   32'(regw_cnt), 32'd0);
    // sw with 2 write stalls: strobe held for all 3 cycles
    run_instr(6'b101011, 6'd0, 1'b0, 0, 2);
    check_eq("sws_cycles", 32'(cyc), 32'd6);
    check_eq("sws_memw",   32'(memw_cnt), 32'd3);

    // beq taken / not taken
    run_instr(6'b000100, 6'd0, 1'b1, 0, 0);
    check_eq("beq1_cycles", 32'(cyc), 32'd3);
    check_eq("beq1_alu",    32'(br_alu), 32'd6);
    check_eq("beq1_pcsrc",  32'(br_pcsrc), 32'd1);
    check_eq("beq1_pcen",   32'(br_pcen), 32'd1);
    run_instr(6'b000100, 6'd0, 1'b0, 0, 0);
    check_eq("beq0_alu",    32'(br_alu), 32'd6);
    check_eq("beq0_pcsrc",  32'(br_pcsrc), 32'd1);
    check_eq("beq0_pcen",   32'(br_pcen), 32'd0);

    // addi
    run_instr(6'b001000, 6'd0, 1'b0, 0, 0);
    check_eq("addi_cycles", 32'(cyc), 32'd4);
    check_eq("addi_regw",   32'(regw_cnt), 32'd1);

    // j
    run_instr(6'b000010, 6'd0, 1'b0, 0, 0);
    check_eq("j_cycles", 32'(cyc), 32'd3);
    check_eq("j_pcsrc",  32'(j_pcsrc), 32'd2);
    check_eq("j_pcen",   32'(j_pcen), 32'd1);

    // Illegal opcode, then R-type with unknown funct
    run_instr(6'b111111, 6'd0, 1'b0, 0, 0);
    check_eq("ill_op_cnt",   32'(ill_cnt), 32'd1);
    check_eq("ill_op_state", 32'(ill_state), 32'd1);
    check_eq("ill_op_cycles", 32'(cyc), 32'd2);
    check_eq("ill_op_wr",    32'(regw_cnt + memw_cnt), 32'd0);
    run_instr(6'b000000, 6'b000000, 1'b0, 0, 0);
    check_eq("ill_fn_cnt",   32'(ill_cnt), 32'd1);
    check_eq("ill_fn_state", 32'(ill_state), 32'd1);
    check_eq("ill_fn_cycles", 32'(cyc), 32'd2);
    check_eq("ill_fn_wr",    32'(regw_cnt + memw_cnt), 32'd0);
    check_eq("ill_fn_final", 32'(State), 32'd0);

    // Legal instructions never pulse Illegal
    run_instr(6'b001000, 6'd0, 1'b0, 0, 0);
    check_eq("legal_no_ill", 32'(ill_cnt), 32'd0);
    check_eq("one_write",    32'(wr_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
